// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter:
//   - default frame constants (data bits per frame, clocks per serial bit)
//   - 2-bit receiver FSM state encoding
//   - uart_width(): bit width needed to count 0 .. n-1 (never less than 1)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_e;

  function automatic int uart_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// 1 so that an idle-high serial line does not produce a false falling edge
// when reset is released.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   d_i    in  asynchronous input
//   q_o    out synchronized output
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1-style UART receiver (1 start, DATA_WIDTH data bits LSB first, 1 stop,
// no parity). The line is synchronized, a falling edge in IDLE starts a
// frame, the start bit is re-checked at mid-bit, and each following bit is
// sampled once per bit period at that same mid-bit phase.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous active-high reset
//   i_RX       in  asynchronous serial line, idle high
//   o_DATA     out last correctly framed word (registered)
//   rx_done    out one-cycle pulse when o_DATA is updated
//   frame_err  out one-cycle pulse when the stop bit is sampled low
//   rx_busy    out high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int CNT_W = uart_width(CLKS_PER_BIT);
  localparam int BIT_W = uart_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic                  rx_s;
  logic                  rx_prev_q;

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (i_RX),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Edge-triggered start: a line that is already low when we come
        // back to IDLE (bad stop bit, break) must not begin a new frame.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting right leaves it at bit 0.
          shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d = shreg_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_DATA    = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Drives serial frames into uart_receiver and compares every rx_done /
// frame_err pulse against a queue of expected events built from the frame
// format: kind of pulse, o_DATA at the pulse, and the cycle it must appear.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int DW  = 8;
  localparam int CPB = 16;
  // Cycles from driving i_RX low (just after an edge) to seeing the pulse:
  // 2 synchronizer flops, then half a bit, DW data bits + stop bit, +1.
  localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB + 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          i_rx  = 1'b1;
  logic [DW-1:0] o_data;
  logic          rx_done;
  logic          frame_err;
  logic          rx_busy;

  int cyc   = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model_last = '0;
  int            exp_pulses = 0;
  int            seen_pulses = 0;

  uart_receiver #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_RX      (i_rx),
    .o_DATA    (o_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest expected event.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      chk("missing_pulse", 32'(cyc), 32'(exp_q[0].due));
      exp_q.delete(0);
    end
    if (rx_done || frame_err) begin
      seen_pulses++;
      chk("exclusive", 32'(rx_done & frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({rx_done, frame_err}), 32'd0);
      end else begin
        mon_e = exp_q[0];
        exp_q.delete(0);
        chk("kind_done", 32'(rx_done), 32'(!mon_e.err));
        chk("kind_ferr", 32'(frame_err), 32'(mon_e.err));
        chk("latency", 32'(cyc), 32'(mon_e.due));
        chk("o_data_at_pulse", 32'(o_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One bit period; an optional 2-cycle inversion early in the bit, well
  // away from the mid-bit sample point, must be ignored by the receiver.
  task automatic drive_bit(input logic b, input bit glitch);
    @(posedge clk); #1 i_rx = b;
    if (glitch) begin
      repeat (2) @(posedge clk); #1 i_rx = ~b;
      repeat (2) @(posedge clk); #1 i_rx = b;
      repeat (CPB - 5) @(posedge clk);
    end else begin
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop_bad, input bit glitch);
    exp_t e;
    @(posedge clk); #1 i_rx = 1'b0;
    e.due = cyc + LAT;
    e.err = stop_bad;
    if (!stop_bad) model_last = d;
    e.data = model_last;
    exp_q.push_back(e);
    exp_pulses++;
    repeat (CPB - 1) @(posedge clk);
    for (int i = 0; i < DW; i++) begin
      drive_bit(d[i], glitch);
      if (i == 0) begin
        #1 chk("busy_mid_frame", 32'(rx_busy), 32'd1);
      end
    end
    drive_bit(!stop_bad, 1'b0);
    if (stop_bad) begin
      @(posedge clk); #1 i_rx = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    i_rx  = 1'b1;
    idle(4);
    #1;
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    idle(5);

    // Single good frame
    send_frame(8'hDB, 1'b0, 1'b0);
    idle(4); #1;
    chk("o_data_db", 32'(o_data), 32'hDB);

    // Short low glitch on an idle line
    @(posedge clk); #1 i_rx = 1'b0;
    repeat (4) @(posedge clk); #1 i_rx = 1'b1;
    idle(20); #1;
    chk("glitch_busy", 32'(rx_busy), 32'd0);
    chk("glitch_o_data", 32'(o_data), 32'hDB);

    // Good frame then a frame with a low stop bit
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20); #1;
    chk("ferr_hold_a5", 32'(o_data), 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b0);
    idle(4); #1;
    chk("b2b_last", 32'(o_data), 32'hA3);

    // Reset during data bit 3 of 0xFF, then a normal frame
    @(posedge clk); #1 i_rx = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    @(posedge clk); #1 i_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_last = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_o_data", 32'(o_data), 32'd0);
    chk("midrst_busy", 32'(rx_busy), 32'd0);
    idle(20);
    send_frame(8'h0F, 1'b0, 1'b0);
    idle(4); #1;
    chk("after_rst_0f", 32'(o_data), 32'h0F);

    // Break: line low for three frame times
    begin
      exp_t e;
      @(posedge clk); #1 i_rx = 1'b0;
      e.due  = cyc + LAT;
      e.err  = 1'b1;
      e.data = model_last;
      exp_q.push_back(e);
      exp_pulses++;
      repeat (LAT + 40) @(posedge clk);
      #1 chk("break_idle_busy", 32'(rx_busy), 32'd0);
      repeat (30 * CPB - LAT - 41) @(posedge clk);
      #1 i_rx = 1'b1;
      idle(20); #1;
      chk("break_end_busy", 32'(rx_busy), 32'd0);
      chk("break_o_data", 32'(o_data), 32'h0F);
    end
    send_frame(8'h81, 1'b0, 1'b0);
    idle(4); #1;
    chk("after_break_81", 32'(o_data), 32'h81);

    // Randomized frames: data, stop-bit errors, mid-bit glitches, gaps
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] d;
      bit            bad;
      bit            gl;
      int            gap;
      d   = DW'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      gl  = ($urandom_range(0, 1) == 1);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
      send_frame(d, bad, gl);
      idle(gap);
    end

    idle(LAT + 20); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(seen_pulses), 32'(exp_pulses));
    chk("final_o_data", 32'(o_data), 32'(model_last));
    chk("final_busy", 32'(rx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 Parameter: CLKS_PER_BIT, 16, clk cycles per serial bit period; even, >= 4.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: i_RX  input  1  asynchronous serial line, idle high.
REQ-006 Port: o_DATA  output  DATA_WIDTH  last correctly framed received word, registered.
REQ-007 Port: rx_done  output  1  one-cycle pulse when o_DATA is updated.
REQ-008 Port: frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 Port: rx_busy  output  1  high in any state other than IDLE.

Function
REQ-010 Frame format SHALL be 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
REQ-011 i_RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: on a 1-to-0 transition of rx_s, go to START and clear the cycle counter; a line already low on IDLE entry SHALL NOT start a frame.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rx_s; if 0, go to DATA with the counter and bit index cleared; if 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register MSB side, shifting right; after DATA_WIDTH samples, go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rx_s; go to IDLE.
REQ-017 If the stop sample is 1, o_DATA SHALL load the shift register and rx_done SHALL pulse high for exactly the next cycle.
REQ-018 If the stop sample is 0, frame_err SHALL pulse high for exactly the next cycle; o_DATA SHALL hold its previous value.
REQ-019 rx_done and frame_err SHALL never be high in the same cycle.
REQ-020 Latency SHALL be fixed: start edge on rx_s to the rx_done/frame_err pulse = CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles.
REQ-021 A new start edge occurring after the stop sample SHALL be accepted, so back-to-back frames are received without loss.
REQ-022 Cycle counter SHALL be wide enough for CLKS_PER_BIT-1; bit index SHALL be wide enough for DATA_WIDTH-1; neither SHALL wrap during a frame.
REQ-023 i_RX activity in DATA/STOP other than at sample points SHALL be ignored.

Reset
REQ-024 While reset is high at a clk edge: state=IDLE, counters=0, shift register=0, o_DATA=0, rx_done=0, frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-025 Reset mid-frame SHALL abandon the frame with no rx_done/frame_err pulse; the next start edge after reset is released SHALL be received normally.

Structure
REQ-026 The FSM state encoding (2-bit localparams IDLE/START/DATA/STOP) SHALL live in a shared uart package together with the default frame constants, shared with uart_transmitter.
REQ-027 The 2-flop input synchronizer SHALL be a separate sub-module, sync_2ff, with reset value 1.

Verification
REQ-028 CLKS_PER_BIT=16, send 0xDB (11011011) -> o_DATA=0xDB, one rx_done pulse at the REQ-020 latency (153 cycles after the rx_s edge), no frame_err.
REQ-029 Low glitch of 4 cycles on an idle line -> state returns to IDLE, no rx_done, o_DATA unchanged.
REQ-030 Frame 0x3C with stop bit forced 0 after a prior 0xA5 -> one frame_err pulse, o_DATA stays 0xA5, no rx_done.
REQ-031 Back-to-back 0x55 then 0xA3 with zero idle gap -> two rx_done pulses, o_DATA=0x55 then 0xA3.
REQ-032 Reset asserted during data bit 3 of 0xFF, then 0x0F sent -> no pulse for the first frame, o_DATA=0x0F with one rx_done.
REQ-033 Line held low for 3 frame times (break) -> exactly one frame_err, no further activity until the line returns high and then falls.
